hdmi_pixel_scan: RTL and testbench



---
 rtl/hdmi_pixel_scan_pkg.sv | 25 ++
 rtl/hdmi_pixel_scan_sfifo.sv | 54 +++++
 rtl/hdmi_pixel_scan.sv | 224 ++++++++++++++++++++++
 tb/tb_hdmi_pixel_scan.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pixel_scan_pkg.sv
// Shared register map, probe register numbers and FSM state type for the
// HDMI pixel scan sequencer.
package hdmi_pixel_scan_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_BASE   = 3'd1;
    localparam logic [2:0] REG_STEP   = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_SETTLE = 3'd4;
    localparam logic [2:0] REG_FIFO   = 3'd5;

    localparam logic [1:0] PROBE_OFF = 2'd1;
    localparam logic [1:0] PROBE_PIX = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WACK,
        ST_SETTLE,
        ST_RD,
        ST_RACK,
        ST_PUSH
    } scan_state_t;

endpackage

// File: rtl/hdmi_pixel_scan_sfifo.sv
// Synchronous result FIFO; a pop frees its slot in time for a push on the
// same cycle, and clear discards everything including a same-cycle push.
module sfifo #(
    parameter int WIDTH  = 30,
    parameter int LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [LGFIFO:0]   fill
);

    localparam int DEPTH = 1 << LGFIFO;

    logic [WIDTH-1:0]  mem [0:DEPTH-1];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign full    = (fill == DEPTH[LGFIFO:0]);
    assign empty   = (fill == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (LGFIFO+1)'(do_push) - (LGFIFO+1)'(do_pop);
        end
    end

endmodule

// File: rtl/hdmi_pixel_scan.sv
// Wishbone-controlled sequencer that steps the HDMI capture probe through an
// arithmetic run of offsets and queues each captured pixel for the CPU.
module hdmi_pixel_scan
    import hdmi_pixel_scan_pkg::*;
#(
    parameter int OFFBITS = 30,
    parameter int LGFIFO  = 4,
    parameter int TMOBITS = 8
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_m_cyc,
    output logic        o_m_stb,
    output logic        o_m_we,
    output logic [1:0]  o_m_addr,
    output logic [31:0] o_m_data,
    input  logic        i_m_stall,
    input  logic        i_m_ack,
    input  logic [31:0] i_m_data,
    output logic        o_int
);

    localparam logic [TMOBITS-1:0] TMO_LAST = ~TMOBITS'(1);

    scan_state_t        state, next_state;
    logic [OFFBITS-1:0] base_reg, step_reg, cur;
    logic [15:0]        count_reg, remaining;
    logic [31:0]        settle_reg, settle_cnt;
    logic [29:0]        pixel, fifo_data;
    logic [TMOBITS-1:0] tmo_cnt;
    logic [LGFIFO:0]    fifo_fill;
    logic [31:0]        rd_mux;
    logic done, err, busy, timeout;
    logic wb_accept, ctrl_wr, start_req, abort_req, clear_req, start_launch;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic unused;

    assign unused       = &{1'b0, i_m_data[31:30]};
    assign o_wb_stall   = 1'b0;
    assign busy         = (state != ST_IDLE);
    assign wb_accept    = i_wb_cyc && i_wb_stb;
    assign ctrl_wr      = wb_accept && i_wb_we && (i_wb_addr == REG_CTRL);
    assign start_req    = ctrl_wr && i_wb_data[0];
    assign abort_req    = ctrl_wr && i_wb_data[1];
    assign clear_req    = ctrl_wr && i_wb_data[2];
    assign start_launch = (state == ST_IDLE) && start_req && !abort_req;
    assign timeout      = ((state == ST_WACK) || (state == ST_RACK)) && !i_m_ack
                          && (tmo_cnt == TMO_LAST);
    assign fifo_pop     = wb_accept && !i_wb_we && (i_wb_addr == REG_FIFO) && !fifo_empty;
    assign fifo_push    = (state == ST_PUSH) && (!fifo_full || fifo_pop);

    sfifo #(.WIDTH(30), .LGFIFO(LGFIFO)) u_fifo (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .clear      (clear_req),
        .push       (fifo_push),
        .wr_data    (pixel),
        .pop        (fifo_pop),
        .rd_data    (fifo_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .fill       (fifo_fill)
    );

    // Scan parameters are frozen for the duration of a run.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            base_reg   <= '0;
            step_reg   <= '0;
            count_reg  <= '0;
            settle_reg <= '0;
        end else if (wb_accept && i_wb_we && !busy) begin
            case (i_wb_addr)
                REG_BASE:   base_reg   <= i_wb_data[OFFBITS-1:0];
                REG_STEP:   step_reg   <= i_wb_data[OFFBITS-1:0];
                REG_COUNT:  count_reg  <= i_wb_data[15:0];
                REG_SETTLE: settle_reg <= i_wb_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_wb_addr)
            REG_CTRL:   rd_mux = {busy, done, err, fifo_full, {(27-LGFIFO){1'b0}}, fifo_fill};
            REG_BASE:   rd_mux = 32'(base_reg);
            REG_STEP:   rd_mux = 32'(step_reg);
            REG_COUNT:  rd_mux = 32'(count_reg);
            REG_SETTLE: rd_mux = settle_reg;
            REG_FIFO:   if (!fifo_empty) rd_mux = {2'b10, fifo_data};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= wb_accept;
            if (wb_accept && !i_wb_we)
                o_wb_data <= rd_mux;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Abort overrides every state, including a probe ack arriving this cycle.
    always_comb begin
        next_state = state;
        if (abort_req) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_launch && count_reg != 16'd0) next_state = ST_WR;
                ST_WR:     if (!i_m_stall) next_state = ST_WACK;
                ST_WACK:   if (i_m_ack) next_state = ST_SETTLE;
                           else if (timeout) next_state = ST_IDLE;
                ST_SETTLE: if (settle_cnt == '0) next_state = ST_RD;
                ST_RD:     if (!i_m_stall) next_state = ST_RACK;
                ST_RACK:   if (i_m_ack) next_state = ST_PUSH;
                           else if (timeout) next_state = ST_IDLE;
                ST_PUSH:   if (fifo_push) next_state = (remaining == 16'd1) ? ST_IDLE : ST_WR;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_m_cyc  = 1'b0;
        o_m_stb  = 1'b0;
        o_m_we   = 1'b0;
        o_m_addr = 2'd0;
        o_m_data = '0;
        case (state)
            ST_WR: begin
                o_m_cyc  = 1'b1;
                o_m_stb  = 1'b1;
                o_m_we   = 1'b1;
                o_m_addr = PROBE_OFF;
                o_m_data = 32'(cur);
            end
            ST_WACK: begin
                o_m_cyc  = 1'b1;
                o_m_we   = 1'b1;
                o_m_addr = PROBE_OFF;
            end
            ST_RD: begin
                o_m_cyc  = 1'b1;
                o_m_stb  = 1'b1;
                o_m_addr = PROBE_PIX;
            end
            ST_RACK: begin
                o_m_cyc  = 1'b1;
                o_m_addr = PROBE_PIX;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            cur        <= '0;
            remaining  <= '0;
            settle_cnt <= '0;
            pixel      <= '0;
            tmo_cnt    <= '0;
        end else begin
            if ((state == ST_WACK) || (state == ST_RACK))
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            case (state)
                ST_IDLE: if (start_launch) begin
                    cur       <= base_reg;
                    remaining <= count_reg;
                end
                ST_WACK:   if (i_m_ack) settle_cnt <= settle_reg;
                ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                ST_RACK:   if (i_m_ack) pixel <= i_m_data[29:0];
                ST_PUSH: if (fifo_push) begin
                    cur       <= cur + step_reg;
                    remaining <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear takes priority over a completion or timeout in the same cycle.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            done  <= 1'b0;
            err   <= 1'b0;
            o_int <= 1'b0;
        end else begin
            if (!abort_req && ((start_launch && count_reg == 16'd0) ||
                               (fifo_push && remaining == 16'd1)))
                done <= 1'b1;
            if (!abort_req && timeout)
                err <= 1'b1;
            if (clear_req) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            o_int <= done | err;
        end
    end

endmodule

// File: tb/tb_hdmi_pixel_scan.sv
// Self-checking bench for hdmi_pixel_scan with a behavioural probe and
// queue-based scoreboards for probe offsets and FIFO results.
module tb_hdmi_pixel_scan;

    logic        i_clk = 1'b0;
    logic        i_areset_n = 1'b0;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [2:0]  i_wb_addr = 3'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_m_cyc, o_m_stb, o_m_we;
    logic [1:0]  o_m_addr;
    logic [31:0] o_m_data;
    logic        i_m_stall = 1'b0, i_m_ack = 1'b0;
    logic [31:0] i_m_data = 32'd0;
    logic        o_int;

    int n_checks = 0;
    int n_fail = 0;
    logic [29:0] exp_off[$];
    logic [29:0] exp_pix[$];
    logic [29:0] obs_off[$];
    logic [1:0]  obs_addr[$];
    bit          no_ack = 1'b0;
    int          read_delay = 1;
    int          ack_cnt = 0;
    logic [29:0] probe_off = 30'd0;

    hdmi_pixel_scan dut (
        .i_clk(i_clk), .i_areset_n(i_areset_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .o_m_we(o_m_we),
        .o_m_addr(o_m_addr), .o_m_data(o_m_data),
        .i_m_stall(i_m_stall), .i_m_ack(i_m_ack), .i_m_data(i_m_data),
        .o_int(o_int)
    );

    always #5 i_clk = ~i_clk;

    // Probe model: records each accepted request and answers with offset*3.
    always @(negedge i_clk) begin
        if (!o_m_cyc) begin
            ack_cnt = 0;
            i_m_ack = 1'b0;
        end else if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            i_m_ack = (ack_cnt == 0);
        end else begin
            i_m_ack = 1'b0;
        end
        if (o_m_cyc && o_m_stb && !i_m_stall) begin
            obs_addr.push_back(o_m_addr);
            if (o_m_we) begin
                obs_off.push_back(o_m_data[29:0]);
                probe_off = o_m_data[29:0];
                if (!no_ack) ack_cnt = 1;
            end else begin
                i_m_data = {2'b00, probe_off * 30'd3};
                ack_cnt = read_delay;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = a; i_wb_data = d;
        @(posedge i_clk);
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d, output logic ack);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
        @(posedge i_clk);
        @(negedge i_clk);
        d = o_wb_data;
        ack = o_wb_ack;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    endtask

    task automatic clear_all();
        wb_write(3'd0, 32'h4);
        exp_off.delete(); exp_pix.delete(); obs_off.delete(); obs_addr.delete();
    endtask

    task automatic configure(input logic [29:0] base, input logic [29:0] step,
                             input logic [15:0] count, input logic [31:0] settle);
        wb_write(3'd1, {2'b00, base});
        wb_write(3'd2, {2'b00, step});
        wb_write(3'd3, {16'd0, count});
        wb_write(3'd4, settle);
    endtask

    task automatic wait_done(input int max_reads, output bit ok);
        logic [31:0] st;
        logic a;
        ok = 1'b0;
        for (int i = 0; i < max_reads; i++) begin
            wb_read(3'd0, st, a);
            if (st[30] || st[29]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_m_cyc, o_m_stb, o_m_we, o_wb_ack, o_int} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL reset_ctl got=%b exp=00000", {o_m_cyc, o_m_stb, o_m_we, o_wb_ack, o_int});
        end
        n_checks++;
        if (o_wb_stall !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_stall got=%b exp=0", o_wb_stall);
        end
        i_areset_n = 1'b1;
        @(negedge i_clk);
        wb_read(3'd0, d, a);
        n_checks++;
        if (a !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_ack got=%b exp=1", a);
        end
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_status got=%h exp=00000000", d);
        end
        wb_read(3'd1, d, a);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_base got=%h exp=00000000", d);
        end
    endtask

    task automatic test_basic_scan();
        logic [31:0] d;
        logic a;
        logic [29:0] e, g;
        logic [1:0] ea;
        bit ok;
        clear_all();
        configure(30'd100, 30'd1920, 16'd3, 32'd10);
        exp_off.push_back(30'd100); exp_off.push_back(30'd2020); exp_off.push_back(30'd3940);
        exp_pix.push_back(30'd300); exp_pix.push_back(30'd6060); exp_pix.push_back(30'd11820);
        wb_write(3'd0, 32'h1);
        wait_done(500, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("[TB] FAIL basic_done_wait got=timeout exp=done");
        end
        n_checks++;
        if (obs_addr.size() != 6) begin
            n_fail++; $display("[TB] FAIL basic_seq_len got=%0d exp=6", obs_addr.size());
        end
        for (int i = 0; i < 6 && obs_addr.size() > 0; i++) begin
            ea = (i % 2 == 0) ? 2'd1 : 2'd2;
            n_checks++;
            if (obs_addr[0] !== ea) begin
                n_fail++; $display("[TB] FAIL basic_seq%0d got=%0d exp=%0d", i, obs_addr[0], ea);
            end
            void'(obs_addr.pop_front());
        end
        while (exp_off.size() > 0) begin
            e = exp_off.pop_front();
            g = (obs_off.size() > 0) ? obs_off.pop_front() : 30'h3FFFFFFF;
            n_checks++;
            if (g !== e) begin
                n_fail++; $display("[TB] FAIL basic_offset got=%h exp=%h", g, e);
            end
        end
        wb_read(3'd0, d, a);
        n_checks++;
        if (d !== 32'h4000_0003) begin
            n_fail++; $display("[TB] FAIL basic_status got=%h exp=40000003", d);
        end
        n_checks++;
        if (o_int !== 1'b1) begin
            n_fail++; $display("[TB] FAIL basic_int got=%b exp=1", o_int);
        end
        while (exp_pix.size() > 0) begin
            e = exp_pix.pop_front();
            wb_read(3'd5, d, a);
            n_checks++;
            if (d !== {2'b10, e}) begin
                n_fail++; $display("[TB] FAIL basic_fifo got=%h exp=%h", d, {2'b10, e});
            end
        end
        wb_read(3'd5, d, a);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("[TB] FAIL basic_empty_read got=%h exp=00000000", d);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] d;
        logic a;
        logic [29:0] e;
        bit ok;
        clear_all();
        configure(30'd0, 30'd1, 16'd20, 32'd0);
        for (int i = 0; i < 20; i++) exp_pix.push_back(30'(3 * i));
        wb_write(3'd0, 32'h1);
        repeat (400) @(negedge i_clk);
        wb_read(3'd0, d, a);
        n_checks++;
        if (d !== 32'h9000_0010) begin
            n_fail++; $display("[TB] FAIL full_halt_status got=%h exp=90000010", d);
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_pix.pop_front();
            wb_read(3'd5, d, a);
            n_checks++;
            if (d !== {2'b10, e}) begin
                n_fail++; $display("[TB] FAIL full_pop%0d got=%h exp=%h", i, d, {2'b10, e});
            end
        end
        wait_done(500, ok);
        wb_read(3'd0, d, a);
        n_checks++;
        if (d !== 32'h5000_0010) begin
            n_fail++; $display("[TB] FAIL full_done_status got=%h exp=50000010", d);
        end
        while (exp_pix.size() > 0) begin
            e = exp_pix.pop_front();
            wb_read(3'd5, d, a);
            n_checks++;
            if (d !== {2'b10, e}) begin
                n_fail++; $display("[TB] FAIL full_drain got=%h exp=%h", d, {2'b10, e});
            end
        end
        n_checks++;
        if (obs_off.size() != 20) begin
            n_fail++; $display("[TB] FAIL full_points got=%0d exp=20", obs_off.size());
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic a;
        int cyc_cycles;
        clear_all();
        no_ack = 1'b1;
        configure(30'd5, 30'd1, 16'd1, 32'd0);
        wb_write(3'd0, 32'h1);
        cyc_cycles = 0;
        while (o_m_cyc && cyc_cycles < 600) begin
            @(negedge i_clk);
            cyc_cycles++;
        end
        n_checks++;
        if (o_m_cyc !== 1'b0 || cyc_cycles < 255 || cyc_cycles > 258) begin
            n_fail++; $display("[TB] FAIL timeout_len got=%0d cycles cyc=%b exp=255..258 cyc=0", cyc_cycles, o_m_cyc);
        end
        wb_read(3'd0, d, a);
        n_checks++;
        if (d !== 32'h2000_0000) begin
            n_fail++; $display("[TB] FAIL timeout_status got=%h exp=20000000", d);
        end
        n_checks++;
        if (o_int !== 1'b1) begin
            n_fail++; $display("[TB] FAIL timeout_int got=%b exp=1", o_int);
        end
        no_ack = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic a;
        logic [29:0] e, g;
        clear_all();
        configure(30'd10, 30'd1, 16'd5, 32'd200);
        exp_off.push_back(30'd10); exp_off.push_back(30'd11); exp_off.push_back(30'd12);
        exp_pix.push_back(30'd30); exp_pix.push_back(30'd33);
        wb_write(3'd0, 32'h1);
        for (int i = 0; i < 1000; i++) begin
            wb_read(3'd0, d, a);
            if (d[4:0] == 5'd2) break;
        end
        repeat (20) @(negedge i_clk);
        wb_write(3'd0, 32'h2);
        n_checks++;
        if (o_m_cyc !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_cyc got=%b exp=0", o_m_cyc);
        end
        wb_read(3'd0, d, a);
        n_checks++;
        if (d !== 32'h0000_0002) begin
            n_fail++; $display("[TB] FAIL abort_status got=%h exp=00000002", d);
        end
        repeat (50) @(negedge i_clk);
        n_checks++;
        if (obs_off.size() != 3 || o_int !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_quiet got=%0d writes int=%b exp=3 writes int=0", obs_off.size(), o_int);
        end
        while (exp_off.size() > 0 && obs_off.size() > 0) begin
            e = exp_off.pop_front();
            g = obs_off.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++; $display("[TB] FAIL abort_offset got=%h exp=%h", g, e);
            end
        end
        while (exp_pix.size() > 0) begin
            e = exp_pix.pop_front();
            wb_read(3'd5, d, a);
            n_checks++;
            if (d !== {2'b10, e}) begin
                n_fail++; $display("[TB] FAIL abort_fifo got=%h exp=%h", d, {2'b10, e});
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic a;
        logic [29:0] e, g;
        bit ok;
        clear_all();
        configure(30'h3FFF_FFFE, 30'd3, 16'd2, 32'd0);
        exp_off.push_back(30'h3FFF_FFFE); exp_off.push_back(30'h0000_0001);
        exp_pix.push_back(30'h3FFF_FFFA); exp_pix.push_back(30'h0000_0003);
        wb_write(3'd0, 32'h1);
        wait_done(300, ok);
        n_checks++;
        if (!ok || obs_off.size() != 2) begin
            n_fail++; $display("[TB] FAIL wrap_run got=%0d writes ok=%b exp=2 writes ok=1", obs_off.size(), ok);
        end
        while (exp_off.size() > 0 && obs_off.size() > 0) begin
            e = exp_off.pop_front();
            g = obs_off.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++; $display("[TB] FAIL wrap_offset got=%h exp=%h", g, e);
            end
        end
        while (exp_pix.size() > 0) begin
            e = exp_pix.pop_front();
            wb_read(3'd5, d, a);
            n_checks++;
            if (d !== {2'b10, e}) begin
                n_fail++; $display("[TB] FAIL wrap_fifo got=%h exp=%h", d, {2'b10, e});
            end
        end
    endtask

    task automatic test_reset_mid_rack();
        logic [31:0] d;
        logic a;
        int n;
        clear_all();
        read_delay = 40;
        configure(30'd7, 30'd1, 16'd1, 32'd0);
        wb_write(3'd0, 32'h1);
        n = 0;
        while (!(o_m_cyc && !o_m_stb && !o_m_we) && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++; $display("[TB] FAIL rack_reach got=timeout exp=RACK");
        end
        #2 i_areset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_m_cyc, o_m_stb, o_m_we, o_m_addr, o_wb_ack, o_int} !== 7'b0 ||
            o_m_data !== 32'd0 || o_wb_data !== 32'd0) begin
            n_fail++; $display("[TB] FAIL async_reset got=%b/%h/%h exp=0",
                {o_m_cyc, o_m_stb, o_m_we, o_m_addr, o_wb_ack, o_int}, o_m_data, o_wb_data);
        end
        @(negedge i_clk);
        i_areset_n = 1'b1;
        read_delay = 1;
        @(negedge i_clk);
        wb_read(3'd0, d, a);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("[TB] FAIL post_reset_status got=%h exp=00000000", d);
        end
        wb_read(3'd5, d, a);
        n_checks++;
        if (d !== 32'd0 || a !== 1'b1) begin
            n_fail++; $display("[TB] FAIL post_reset_fifo got=%h ack=%b exp=00000000 ack=1", d, a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_fifo_full();
        test_timeout();
        test_abort();
        test_wrap();
        test_reset_mid_rack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
